cv_mem_mapper: RTL

- Parametrised successor to the fixed Coleco/ADAM address decoder.
- Splits the 64K Z80 space into NUM_WIN equal windows. Each window has a run-time register that selects a source (system ROM, RAM, cartridge, expansion) and a page within it.
- Registers load through I/O ports, a legacy 0x7F port and a MegaCart-style read hotspot.
- Inserts wait states for slow sources. Sits between the T80 bus and the memory/cartridge controllers.

---
 rtl/cv_mapper_pkg.sv | 39 +++
 rtl/cv_wait_gen.sv | 69 ++++++
 rtl/cv_mem_mapper.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cv_mapper_pkg.sv
// Shared types for the Coleco/ADAM window mapper: source codes, per-window
// config word, wait-FSM states and the legacy 0x7F port remap.
package cv_mapper_pkg;

    // Stored page width; narrower PAGE_W builds keep the upper bits at zero.
    localparam int unsigned MaxPageW = 6;

    typedef enum logic [1:0] {
        SRC_ROM  = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_CART = 2'd2,
        SRC_EXP  = 2'd3
    } src_t;

    typedef struct packed {
        src_t                src;
        logic [MaxPageW-1:0] page;
    } win_cfg_t;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StHold
    } wait_state_t;

    // ADAM memory-map codes; the same code means different sources in the
    // lower and upper halves of the address space.
    function automatic src_t legacy_remap(input logic [1:0] code, input logic upper);
        src_t src;
        unique case (code)
            2'b11:   src = upper ? SRC_CART : SRC_ROM;
            2'b01:   src = SRC_RAM;
            2'b00:   src = upper ? SRC_RAM : SRC_ROM;
            default: src = SRC_EXP;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/cv_wait_gen.sv
// Wait-state generator: pulls WAIT low for WAIT_EXP clocks at the start of
// every memory access (not refresh) aimed at the expansion source.
module cv_wait_gen
    import cv_mapper_pkg::*;
#(
    parameter int unsigned WAIT_EXP = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic mreq_n_i,
    input  logic rfsh_n_i,
    input  logic exp_sel_i,
    output logic wait_n_o
);

    localparam int unsigned    CntW    = (WAIT_EXP > 1) ? $clog2(WAIT_EXP + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_EXP);
    localparam logic            WaitOn  = (WAIT_EXP > 0);

    wait_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mreq_n_q;
    logic            mreq_fall;

    assign mreq_fall = mreq_n_q & ~mreq_n_i;

    // State, counter and MREQ history registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mreq_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mreq_n_q <= mreq_n_i;
        end
    end

    // Next state; WAIT is low for the whole of StCount only.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_n_o = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (WaitOn && mreq_fall && rfsh_n_i && exp_sel_i) begin
                    state_d = StCount;
                    cnt_d   = CntLoad;
                end
            end
            StCount: begin
                wait_n_o = 1'b0;
                if (cnt_q <= CntW'(1)) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (mreq_n_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/cv_mem_mapper.sv
// Window-based Z80 memory mapper for Coleco/ADAM. The 64K space is split into
// 2**WIN_BITS windows, each mapped to a source/page by a run-time register.
// Optional build macro CV_MAPPER_READBACK_EN adds I/O readback of the config
// registers on d_o/d_oe_o.
module cv_mem_mapper
    import cv_mapper_pkg::*;
#(
    parameter int unsigned WIN_BITS    = 2,
    parameter int unsigned PAGE_W      = 6,
    parameter logic [7:0]  CFG_PORT    = 8'h40,
    parameter logic [7:0]  LEGACY_PORT = 8'h7F,
    parameter int unsigned HOT_WIN     = (1 << WIN_BITS) - 1,
    parameter int unsigned WAIT_EXP    = 2
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                adam_mode_i,
    input  logic [15:0]         a_i,
    input  logic [7:0]          d_i,
    input  logic                iorq_n_i,
    input  logic                mreq_n_i,
    input  logic                rd_n_i,
    input  logic                wr_n_i,
    input  logic                rfsh_n_i,
    input  logic [PAGE_W-1:0]   cart_mask_i,
    output logic [3:0]          ce_n_o,
    output logic [PAGE_W-1:0]   page_o,
    output logic [WIN_BITS-1:0] win_o,
    output logic                wait_n_o
`ifdef CV_MAPPER_READBACK_EN
    ,
    output logic [7:0]          d_o,
    output logic                d_oe_o
`endif
);

    localparam int unsigned         NumWin   = 1 << WIN_BITS;
    localparam int unsigned         HalfWin  = NumWin / 2;
    localparam logic [MaxPageW-1:0] PageMask = MaxPageW'((1 << PAGE_W) - 1);
    localparam logic [WIN_BITS-1:0] HotIdx   = WIN_BITS'(HOT_WIN);

    win_cfg_t              win_cfg_q [NumWin];
    win_cfg_t              win_cfg_d [NumWin];
    win_cfg_t              rst_cfg   [NumWin];
    win_cfg_t              cur_cfg;
    logic [WIN_BITS-1:0]   win;
    logic [MaxPageW-1:0]   mask_ext;
    logic                  io_wr, io_wr_q, io_load;
    logic                  hot_en, hot_trig, hot_q, hot_load;

    assign win      = a_i[15 -: WIN_BITS];
    assign cur_cfg  = win_cfg_q[win];
    assign mask_ext = MaxPageW'(cart_mask_i);

    // Any cartridge bigger than two pages (mask bit 1 or above set) is banked.
    assign hot_en   = |mask_ext[MaxPageW-1:1];
    assign hot_trig = hot_en & (win_cfg_q[HotIdx].src == SRC_CART) & ~mreq_n_i & ~rd_n_i
                      & rfsh_n_i & (a_i[15:6] == 10'h3FF);
    assign hot_load = hot_trig & ~hot_q;

    assign io_wr   = ~iorq_n_i & mreq_n_i & rfsh_n_i & ~wr_n_i;
    assign io_load = io_wr & ~io_wr_q;

    // Reset memory map, selected by adam_mode_i while reset is held.
    always_comb begin
        for (int unsigned w = 0; w < NumWin; w++) begin
            if (adam_mode_i) begin
                if (w < HalfWin) begin
                    rst_cfg[w] = '{src: SRC_ROM, page: MaxPageW'(1) & PageMask};
                end else begin
                    rst_cfg[w] = '{src: SRC_RAM, page: MaxPageW'(w) & PageMask};
                end
            end else if (w == 0) begin
                rst_cfg[w] = '{src: SRC_ROM, page: '0};
            end else if (w < HalfWin) begin
                rst_cfg[w] = '{src: SRC_RAM, page: MaxPageW'(w) & PageMask};
            end else begin
                rst_cfg[w] = '{src: SRC_CART, page: MaxPageW'(w - HalfWin) & PageMask};
            end
        end
    end

    // Register updates; I/O writes are applied last so they win over the hotspot.
    always_comb begin
        win_cfg_d = win_cfg_q;
        if (hot_load) begin
            win_cfg_d[HotIdx].page = a_i[5:0] & mask_ext & PageMask;
        end
        if (io_load) begin
            for (int unsigned w = 0; w < NumWin; w++) begin
                if (a_i[7:0] == 8'(CFG_PORT + w)) begin
                    win_cfg_d[w] = '{src: src_t'(d_i[7:6]), page: d_i[5:0] & PageMask};
                end
                if (a_i[7:0] == LEGACY_PORT) begin
                    win_cfg_d[w].src = (w < HalfWin) ? legacy_remap(d_i[1:0], 1'b0)
                                                     : legacy_remap(d_i[3:2], 1'b1);
                end
            end
        end
    end

    // Config registers and strobe history for single-shot loading.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            win_cfg_q <= rst_cfg;
            io_wr_q   <= 1'b0;
            hot_q     <= 1'b0;
        end else begin
            win_cfg_q <= win_cfg_d;
            io_wr_q   <= io_wr;
            hot_q     <= hot_trig;
        end
    end

    // Chip enables and page for the window currently addressed.
    always_comb begin
        ce_n_o = 4'hF;
        if (~mreq_n_i & rfsh_n_i) begin
            ce_n_o[cur_cfg.src] = 1'b0;
        end
        page_o = cur_cfg.page[PAGE_W-1:0];
        win_o  = win;
    end

`ifdef CV_MAPPER_READBACK_EN
    // Config readback during I/O reads of the per-window ports.
    always_comb begin
        d_o    = '0;
        d_oe_o = 1'b0;
        if (~iorq_n_i & ~rd_n_i) begin
            for (int unsigned w = 0; w < NumWin; w++) begin
                if (a_i[7:0] == 8'(CFG_PORT + w)) begin
                    d_o    = {win_cfg_q[w].src, win_cfg_q[w].page};
                    d_oe_o = 1'b1;
                end
            end
        end
    end
`endif

    cv_wait_gen #(
        .WAIT_EXP (WAIT_EXP)
    ) u_wait_gen (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .mreq_n_i  (mreq_n_i),
        .rfsh_n_i  (rfsh_n_i),
        .exp_sel_i (cur_cfg.src == SRC_EXP),
        .wait_n_o  (wait_n_o)
    );

endmodule
